demapper_byte_ram_bt_ble: RTL

//  Receive-direction buffer of the BLE PHY: the counterpart of the TX mapper bit RAM.

---
 rtl/demapper_byte_ram_bt_ble_pkg.sv | 5 +
 rtl/demapper_byte_fifo_bt_ble.sv | 59 +++++
 rtl/demapper_byte_ram_bt_ble.sv | 78 +++++++
 3 files changed

// File: rtl/demapper_byte_ram_bt_ble_pkg.sv
// demapper_byte_ram_bt_ble_pkg: shared widths for the BLE RX byte buffer
package demapper_byte_ram_bt_ble_pkg;
  localparam int BT_BLE_BYTE_W = 8;
  localparam int BT_BLE_BITCNT_W = 3;
endpackage

// File: rtl/demapper_byte_fifo_bt_ble.sv
// demapper_byte_fifo_bt_ble: byte-wide circular RAM with occupancy count and read strobe
module demapper_byte_fifo_bt_ble
  import demapper_byte_ram_bt_ble_pkg::*;
#(
  parameter int AD_PL_DEM  = 11,
  parameter int MEM_PL_DEM = 2048
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [BT_BLE_BYTE_W-1:0] wr_data,
  input  logic                     rd_req,
  output logic [BT_BLE_BYTE_W-1:0] byte_out,
  output logic                     byte_valid,
  output logic                     empty,
  output logic                     full,
  output logic [AD_PL_DEM:0]       count
);
  localparam logic [AD_PL_DEM:0] MEM_CNT = (AD_PL_DEM+1)'(MEM_PL_DEM);
  logic [BT_BLE_BYTE_W-1:0] ram [MEM_PL_DEM];
  logic [AD_PL_DEM-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AD_PL_DEM:0] count_q, count_d;
  logic [BT_BLE_BYTE_W-1:0] byte_out_q, byte_out_d;
  logic byte_valid_q, byte_valid_d, do_wr, do_rd;
  // full/empty come from the pre-edge count, so a same-edge read never frees room for a commit
  always_comb begin
    do_wr = wr_en && !full && !flush;
    do_rd = rd_req && !empty && !flush;
    wr_ptr_d = flush ? '0 : wr_ptr_q + AD_PL_DEM'(do_wr);
    rd_ptr_d = flush ? '0 : rd_ptr_q + AD_PL_DEM'(do_rd);
    count_d = flush ? '0 : count_q + (AD_PL_DEM+1)'(do_wr) - (AD_PL_DEM+1)'(do_rd);
    byte_out_d = do_rd ? ram[rd_ptr_q] : byte_out_q;
    byte_valid_d = do_rd;
  end
  always_ff @(posedge clk) begin
    if (do_wr) ram[wr_ptr_q] <= wr_data;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      byte_out_q <= '0;
      byte_valid_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      byte_out_q <= byte_out_d;
      byte_valid_q <= byte_valid_d;
    end
  end
  assign full = count_q == MEM_CNT;
  assign empty = count_q == '0;
  assign count = count_q;
  assign byte_out = byte_out_q;
  assign byte_valid = byte_valid_q;
endmodule

// File: rtl/demapper_byte_ram_bt_ble.sv
// demapper_byte_ram_bt_ble: packs serial demodulated bits LSB-first into bytes
// and buffers them in a circular RAM drained by the MAC side
module demapper_byte_ram_bt_ble
  import demapper_byte_ram_bt_ble_pkg::*;
#(
  parameter int AD_PL_DEM   = 11,
  parameter int MEM_PL_DEM  = 2048,
  parameter int DATA_PL_DEM = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   bit_in,
  input  logic                   bit_valid,
  input  logic                   flush,
  input  logic                   rd_req,
  output logic [DATA_PL_DEM-1:0] byte_out,
  output logic                   byte_valid,
  output logic                   empty,
  output logic                   full,
  output logic [AD_PL_DEM:0]     count,
  output logic                   overflow
);
  logic [DATA_PL_DEM-1:0] shift_q, shift_d, pack_q, pack_d;
  logic [BT_BLE_BITCNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic wr_pend_q, wr_pend_d, overflow_q, overflow_d;
  // the completed byte is taken from shift_d so the 8th bit lands in bit 7 on the same edge
  always_comb begin
    shift_d = shift_q;
    bit_cnt_d = bit_cnt_q;
    pack_d = pack_q;
    wr_pend_d = 1'b0;
    overflow_d = overflow_q | (wr_pend_q & full);
    if (flush) begin
      shift_d = '0;
      bit_cnt_d = '0;
      overflow_d = 1'b0;
    end else if (bit_valid) begin
      shift_d[bit_cnt_q] = bit_in;
      bit_cnt_d = bit_cnt_q + 1'b1;
      if (bit_cnt_q == '1) begin
        pack_d = shift_d;
        wr_pend_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q <= '0;
      bit_cnt_q <= '0;
      pack_q <= '0;
      wr_pend_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      pack_q <= pack_d;
      wr_pend_q <= wr_pend_d;
      overflow_q <= overflow_d;
    end
  end
  demapper_byte_fifo_bt_ble #(
    .AD_PL_DEM (AD_PL_DEM),
    .MEM_PL_DEM(MEM_PL_DEM)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .wr_en     (wr_pend_q),
    .wr_data   (pack_q),
    .rd_req    (rd_req),
    .byte_out  (byte_out),
    .byte_valid(byte_valid),
    .empty     (empty),
    .full      (full),
    .count     (count)
  );
  assign overflow = overflow_q;
endmodule
